// File: rtl/cv32e40p_apu_resp_pkg.sv
// Shared types and helpers for the APU response buffer: the buffered result
// record and the counter width rule used by the FIFO and the credit logic.
package cv32e40p_apu_resp_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAGS_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0]  rdata;
        logic [FLAGS_W-1:0] rflags;
    } apu_resp_t;

    // Counters must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cv32e40p_apu_resp_buffer_if.sv
// Handshake bundle between the core APU port, the response buffer and the FPU
// wrapper. The master side drives the core/FPU inputs, the slave is the buffer.
interface cv32e40p_apu_resp_buffer_if;
    import cv32e40p_apu_resp_pkg::*;

    logic               core_req_i;
    logic               core_gnt_o;
    logic               fpu_req_o;
    logic               fpu_gnt_i;
    logic               fpu_rvalid_i;
    logic [DATA_W-1:0]  fpu_rdata_i;
    logic [FLAGS_W-1:0] fpu_rflags_i;
    logic               core_rvalid_o;
    logic [DATA_W-1:0]  core_rdata_o;
    logic [FLAGS_W-1:0] core_rflags_o;
    logic               core_rready_i;
    logic               busy_o;
    logic               spurious_o;

    modport master (
        output core_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, core_rready_i,
        input  core_gnt_o, fpu_req_o, core_rvalid_o, core_rdata_o, core_rflags_o, busy_o,
               spurious_o
    );

    modport slave (
        input  core_req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, core_rready_i,
        output core_gnt_o, fpu_req_o, core_rvalid_o, core_rdata_o, core_rflags_o, busy_o,
               spurious_o
    );

endinterface

// File: rtl/cv32e40p_apu_resp_fifo.sv
// Synchronous FIFO of APU results. Head is read combinationally; push and pop
// in the same cycle are accepted even when full. Storage is cleared on reset.
module cv32e40p_apu_resp_fifo
    import cv32e40p_apu_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  apu_resp_t                data_i,
    input  logic                     pop_i,
    output apu_resp_t                data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o
);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    apu_resp_t         mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = push_ok ? wrap_inc(wptr_q) : wptr_q;
        rptr_d  = pop_ok ? wrap_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_apu_resp_buffer.sv
// Result buffer between the core APU port and a non-stallable FPU: credits
// bound inflight + stored results to DEPTH so no FPU result is ever dropped.
module cv32e40p_apu_resp_buffer
    import cv32e40p_apu_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                       clk_i,
    input logic                       rst_i,
    cv32e40p_apu_resp_buffer_if.slave bus
);
    localparam int unsigned CW      = cnt_w(DEPTH);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;
    logic          spurious_q, spurious_d;
    logic          has_credit, issue, push, pop;
    logic          fifo_full, fifo_empty, fifo_push;
    apu_resp_t     fifo_wdata, fifo_rdata;

    assign used       = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign has_credit = (used < DEPTH_L);

    assign bus.fpu_req_o  = bus.core_req_i & has_credit;
    assign bus.core_gnt_o = bus.fpu_gnt_i & has_credit;

    assign issue = bus.core_req_i & bus.fpu_gnt_i & has_credit;
    assign push  = bus.fpu_rvalid_i & (inflight_q != '0);
    assign pop   = ~fifo_empty & bus.core_rready_i;

    // Credits already exclude overflow; the full check only keeps the FIFO contract explicit.
    assign fifo_push  = push & (~fifo_full | pop);
    assign fifo_wdata = '{rdata: bus.fpu_rdata_i, rflags: bus.fpu_rflags_i};

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        spurious_d = spurious_q | (bus.fpu_rvalid_i & (inflight_q == '0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            spurious_q <= spurious_d;
        end
    end

    cv32e40p_apu_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.core_rvalid_o = ~fifo_empty;
    assign bus.core_rdata_o  = fifo_rdata.rdata;
    assign bus.core_rflags_o = fifo_rdata.rflags;
    assign bus.busy_o        = (inflight_q != '0) | ~fifo_empty;
    assign bus.spurious_o    = spurious_q;

endmodule

// File: tb/tb_cv32e40p_apu_resp_buffer.sv
// Bench for the APU response buffer: a fill table, directed corner sequences and
// random traffic, all checked against a queue-based model of the buffer.
module tb_cv32e40p_apu_resp_buffer;
    import cv32e40p_apu_resp_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cv32e40p_apu_resp_buffer_if bus ();

    cv32e40p_apu_resp_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: stored results in arrival order, ops in flight, sticky spurious flag.
    apu_resp_t m_q [$];
    int        m_inflight = 0;
    bit        m_spur     = 1'b0;
    bit        last_issue = 1'b0;

    typedef struct {
        int                 due;
        logic [DATA_W-1:0]  d;
        logic [FLAGS_W-1:0] f;
    } pend_t;
    pend_t pend [$];

    typedef struct {
        bit                 req, gnt, rv;
        logic [DATA_W-1:0]  rd;
        logic [FLAGS_W-1:0] rf;
        bit                 rr;
        bit                 e_req, e_gnt, e_rv;
        logic [DATA_W-1:0]  e_rd;
        logic [FLAGS_W-1:0] e_rf;
        bit                 e_busy;
    } vec_t;
    vec_t tbl [12];

    function automatic vec_t mk(input bit req, gnt, rv, input logic [31:0] rd,
                                input logic [4:0] rf, input bit rr, input bit e_req, e_gnt,
                                e_rv, input logic [31:0] e_rd, input logic [4:0] e_rf,
                                input bit e_busy);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rf = rf; v.rr = rr;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd; v.e_rf = e_rf;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit req, gnt, rv, input logic [31:0] rd, input logic [4:0] rf,
                         input bit rr);
        bus.core_req_i    = req;
        bus.fpu_gnt_i     = gnt;
        bus.fpu_rvalid_i  = rv;
        bus.fpu_rdata_i   = rd;
        bus.fpu_rflags_i  = rf;
        bus.core_rready_i = rr;
        #1;
    endtask

    task automatic check_model();
        int credits;
        bit e_rv;
        credits = DEPTH - m_inflight - m_q.size();
        e_rv    = (m_q.size() != 0);
        check("fpu_req_o", 32'(bus.fpu_req_o), 32'(bus.core_req_i && credits != 0));
        check("core_gnt_o", 32'(bus.core_gnt_o), 32'(bus.fpu_gnt_i && credits != 0));
        check("core_rvalid_o", 32'(bus.core_rvalid_o), 32'(e_rv));
        check("busy_o", 32'(bus.busy_o), 32'(m_inflight != 0 || e_rv));
        check("spurious_o", 32'(bus.spurious_o), 32'(m_spur));
        if (e_rv) begin
            check("core_rdata_o", 32'(bus.core_rdata_o), 32'(m_q[0].rdata));
            check("core_rflags_o", 32'(bus.core_rflags_o), 32'(m_q[0].rflags));
        end
    endtask

    task automatic advance();
        bit e_rv;
        e_rv       = (m_q.size() != 0);
        last_issue = bus.core_req_i && bus.fpu_gnt_i && (DEPTH - m_inflight - m_q.size() != 0);
        if (e_rv && bus.core_rready_i) void'(m_q.pop_front());
        if (bus.fpu_rvalid_i) begin
            if (m_inflight > 0) begin
                m_q.push_back('{rdata: bus.fpu_rdata_i, rflags: bus.fpu_rflags_i});
                m_inflight--;
            end else begin
                m_spur = 1'b1;
            end
        end
        if (last_issue) m_inflight++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle(input bit req, gnt, rv, input logic [31:0] rd, input logic [4:0] rf,
                         input bit rr);
        drive(req, gnt, rv, rd, rf, rr);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        pend.delete();
        m_inflight = 0;
        m_spur     = 1'b0;
        cyc++;
    endtask

    // FPU side: results leave in issue order once their latency has elapsed.
    task automatic fpu_pick(output bit rv, output logic [31:0] rd, output logic [4:0] rf);
        rv = 1'b0;
        rd = '0;
        rf = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            rv = 1'b1;
            rd = pend[0].d;
            rf = pend[0].f;
            void'(pend.pop_front());
        end
    endtask

    task automatic fpu_track(input int lat);
        if (last_issue) pend.push_back('{due: cyc - 1 + lat, d: $urandom, f: 5'($urandom)});
    endtask

    task automatic auto_cycle(input bit req, gnt, rr, input int lat);
        bit rv;
        logic [31:0] rd;
        logic [4:0] rf;
        fpu_pick(rv, rd, rf);
        drive(req, gnt, rv, rd, rf, rr);
        check_model();
        advance();
        fpu_track(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        tbl[0]  = mk(1, 1, 0, 32'h0,         5'h00, 0, 1, 1, 0, 32'h0,         5'h00, 0);
        tbl[1]  = mk(1, 1, 0, 32'h0,         5'h00, 0, 1, 1, 0, 32'h0,         5'h00, 1);
        tbl[2]  = mk(1, 1, 1, 32'hA000_0001, 5'h01, 0, 1, 1, 0, 32'h0,         5'h00, 1);
        tbl[3]  = mk(1, 1, 1, 32'hB000_0002, 5'h02, 0, 1, 1, 1, 32'hA000_0001, 5'h01, 1);
        tbl[4]  = mk(1, 1, 1, 32'hC000_0003, 5'h03, 0, 0, 0, 1, 32'hA000_0001, 5'h01, 1);
        tbl[5]  = mk(1, 1, 1, 32'hD000_0004, 5'h04, 0, 0, 0, 1, 32'hA000_0001, 5'h01, 1);
        tbl[6]  = mk(1, 1, 0, 32'h0,         5'h00, 0, 0, 0, 1, 32'hA000_0001, 5'h01, 1);
        tbl[7]  = mk(0, 0, 0, 32'h0,         5'h00, 1, 0, 0, 1, 32'hA000_0001, 5'h01, 1);
        tbl[8]  = mk(0, 0, 0, 32'h0,         5'h00, 1, 0, 0, 1, 32'hB000_0002, 5'h02, 1);
        tbl[9]  = mk(0, 0, 0, 32'h0,         5'h00, 1, 0, 0, 1, 32'hC000_0003, 5'h03, 1);
        tbl[10] = mk(0, 0, 0, 32'h0,         5'h00, 1, 0, 0, 1, 32'hD000_0004, 5'h04, 1);
        tbl[11] = mk(0, 0, 0, 32'h0,         5'h00, 0, 0, 0, 0, 32'h0,         5'h00, 0);

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        do_reset();
        do_reset();

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("reset.core_rvalid_o", 32'(bus.core_rvalid_o), 32'd0);
        check("reset.busy_o", 32'(bus.busy_o), 32'd0);
        check("reset.spurious_o", 32'(bus.spurious_o), 32'd0);
        check("reset.core_rdata_o", 32'(bus.core_rdata_o), 32'd0);
        check("reset.core_rflags_o", 32'(bus.core_rflags_o), 32'd0);
        check_model();
        advance();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rf, tbl[i].rr);
            check($sformatf("fill%0d.fpu_req_o", i), 32'(bus.fpu_req_o), 32'(tbl[i].e_req));
            check($sformatf("fill%0d.core_gnt_o", i), 32'(bus.core_gnt_o), 32'(tbl[i].e_gnt));
            check($sformatf("fill%0d.core_rvalid_o", i), 32'(bus.core_rvalid_o),
                  32'(tbl[i].e_rv));
            check($sformatf("fill%0d.busy_o", i), 32'(bus.busy_o), 32'(tbl[i].e_busy));
            if (tbl[i].e_rv) begin
                check($sformatf("fill%0d.core_rdata_o", i), 32'(bus.core_rdata_o),
                      32'(tbl[i].e_rd));
                check($sformatf("fill%0d.core_rflags_o", i), 32'(bus.core_rflags_o),
                      32'(tbl[i].e_rf));
            end
            check_model();
            advance();
        end

        // Back-to-back: one issue per cycle, FPU latency 2, core always ready.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bit rv;
            logic [31:0] rd;
            logic [4:0] rf;
            fpu_pick(rv, rd, rf);
            drive(1'b1, 1'b1, rv, rd, rf, 1'b1);
            check("b2b.fpu_req_o", 32'(bus.fpu_req_o), 32'd1);
            if (i >= 3) check("b2b.core_rvalid_o", 32'(bus.core_rvalid_o), 32'd1);
            check_model();
            advance();
            fpu_track(2);
        end
        for (int i = 0; i < 10; i++) begin
            if (pend.size() == 0 && m_q.size() == 0) break;
            auto_cycle(1'b0, 1'b0, 1'b1, 2);
        end
        check("b2b.drained_busy_o", 32'(bus.busy_o), 32'd0);

        // Push and pop together with three stored and one in flight.
        do_reset();
        repeat (4) cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hC0DE_0001, 5'h11, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hC0DE_0002, 5'h12, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hC0DE_0003, 5'h13, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'hC0DE_0004, 5'h14, 1'b1);
        check("pp.head", 32'(bus.core_rdata_o), 32'hC0DE_0001);
        check_model();
        advance();
        check("pp.spurious_o", 32'(bus.spurious_o), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
            if (bus.core_rvalid_o) n++;
            check_model();
            advance();
        end
        check("pp.drained_count", 32'(n), 32'd3);

        // Stalled head stays stable while a second result arrives.
        do_reset();
        repeat (2) cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h5A5A_0001, 5'h0A, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) drive(1'b0, 1'b0, 1'b1, 32'h5A5A_0002, 5'h0B, 1'b0);
            else        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
            check("hold.core_rvalid_o", 32'(bus.core_rvalid_o), 32'd1);
            check("hold.core_rdata_o", 32'(bus.core_rdata_o), 32'h5A5A_0001);
            check("hold.core_rflags_o", 32'(bus.core_rflags_o), 32'h0A);
            check_model();
            advance();
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
            if (bus.core_rvalid_o) n++;
            check_model();
            advance();
        end
        check("hold.drained_count", 32'(n), 32'd2);

        // Reset with two in flight and one stored; the late result is spurious.
        do_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h7777_0001, 5'h07, 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("rstmid.core_rvalid_o", 32'(bus.core_rvalid_o), 32'd0);
        check("rstmid.fpu_req_o", 32'(bus.fpu_req_o), 32'd1);
        check("rstmid.busy_o", 32'(bus.busy_o), 32'd0);
        check("rstmid.spurious_o", 32'(bus.spurious_o), 32'd0);
        check_model();
        advance();
        cycle(1'b0, 1'b0, 1'b1, 32'h7777_0002, 5'h08, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("rstmid.late_spurious_o", 32'(bus.spurious_o), 32'd1);
        check("rstmid.late_core_rvalid_o", 32'(bus.core_rvalid_o), 32'd0);
        check_model();
        advance();

        // Spurious result with nothing in flight; sticky until reset.
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'h1F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
            check("spur.spurious_o", 32'(bus.spurious_o), 32'd1);
            check("spur.core_rvalid_o", 32'(bus.core_rvalid_o), 32'd0);
            check_model();
            advance();
        end
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("spur.cleared_by_reset", 32'(bus.spurious_o), 32'd0);
        check_model();
        advance();

        // Random traffic with random FPU latency; late in the run, stray results.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit rv;
            logic [31:0] rd;
            logic [4:0] rf;
            fpu_pick(rv, rd, rf);
            if (!rv && pend.size() == 0 && i > 250 && $urandom_range(0, 39) == 0) begin
                rv = 1'b1;
                rd = $urandom;
                rf = 5'($urandom);
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, rv, rd, rf,
                  $urandom_range(0, 9) < 6);
            check_model();
            advance();
            fpu_track(int'($urandom_range(1, 4)));
        end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (pend.size() == 0 && m_q.size() == 0) break;
            auto_cycle(1'b0, 1'b0, 1'b1, 1);
            n++;
        end
        check("rand.drain_within_bound", 32'(pend.size() + m_q.size()), 32'd0);
        check("rand.final_busy_o", 32'(bus.busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
